// File: rtl/jtag_pkg.sv
// Shared TAP definitions: 4-bit state codes, default opcodes, IDCODE and IR capture pattern.
package jtag_pkg;

  localparam logic [3:0] TAP_TEST_LOGIC_RESET = 4'd0;
  localparam logic [3:0] TAP_RUN_TEST_IDLE    = 4'd1;
  localparam logic [3:0] TAP_SELECT_DR        = 4'd2;
  localparam logic [3:0] TAP_CAPTURE_DR       = 4'd3;
  localparam logic [3:0] TAP_SHIFT_DR         = 4'd4;
  localparam logic [3:0] TAP_EXIT1_DR         = 4'd5;
  localparam logic [3:0] TAP_PAUSE_DR         = 4'd6;
  localparam logic [3:0] TAP_EXIT2_DR         = 4'd7;
  localparam logic [3:0] TAP_UPDATE_DR        = 4'd8;
  localparam logic [3:0] TAP_SELECT_IR        = 4'd9;
  localparam logic [3:0] TAP_CAPTURE_IR       = 4'd10;
  localparam logic [3:0] TAP_SHIFT_IR         = 4'd11;
  localparam logic [3:0] TAP_EXIT1_IR         = 4'd12;
  localparam logic [3:0] TAP_PAUSE_IR         = 4'd13;
  localparam logic [3:0] TAP_EXIT2_IR         = 4'd14;
  localparam logic [3:0] TAP_UPDATE_IR        = 4'd15;

  localparam logic [3:0]  JTAG_IR_IDCODE  = 4'b1110;
  localparam logic [3:0]  JTAG_IR_USER    = 4'b1010;
  localparam logic [31:0] JTAG_IDCODE     = 32'h000FAF01;
  localparam logic [1:0]  JTAG_IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: state register plus TMS-driven next-state logic on tck rise.
// Latency: state follows tms one tck rise later; no backpressure (tck-paced).
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms,
  output logic [3:0] state
);

  logic [3:0] r_state;
  logic [3:0] w_next;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) r_state <= TAP_TEST_LOGIC_RESET;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      TAP_TEST_LOGIC_RESET: w_next = tms ? TAP_TEST_LOGIC_RESET : TAP_RUN_TEST_IDLE;
      TAP_RUN_TEST_IDLE:    w_next = tms ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
      TAP_SELECT_DR:        w_next = tms ? TAP_SELECT_IR        : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR:       w_next = tms ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
      TAP_SHIFT_DR:         w_next = tms ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
      TAP_EXIT1_DR:         w_next = tms ? TAP_UPDATE_DR        : TAP_PAUSE_DR;
      TAP_PAUSE_DR:         w_next = tms ? TAP_EXIT2_DR         : TAP_PAUSE_DR;
      TAP_EXIT2_DR:         w_next = tms ? TAP_UPDATE_DR        : TAP_SHIFT_DR;
      TAP_UPDATE_DR:        w_next = tms ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
      TAP_SELECT_IR:        w_next = tms ? TAP_TEST_LOGIC_RESET : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR:       w_next = tms ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
      TAP_SHIFT_IR:         w_next = tms ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
      TAP_EXIT1_IR:         w_next = tms ? TAP_UPDATE_IR        : TAP_PAUSE_IR;
      TAP_PAUSE_IR:         w_next = tms ? TAP_EXIT2_IR         : TAP_PAUSE_IR;
      TAP_EXIT2_IR:         w_next = tms ? TAP_UPDATE_IR        : TAP_SHIFT_IR;
      TAP_UPDATE_IR:        w_next = tms ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
      default:              w_next = TAP_TEST_LOGIC_RESET;
    endcase
  end

  assign state = r_state;

endmodule

// File: rtl/jtag_tap.sv
// TAP datapath: IR, IDCODE/BYPASS/user DRs shifted LSB-first, tdo launched on tck fall.
// Latency: user_dr/ir update on the rise leaving Update; tdo half a tck after the shift edge.
module jtag_tap
  import jtag_pkg::*;
#(
  parameter int unsigned          IR_WIDTH     = 4,
  parameter logic [31:0]          IDCODE_VALUE = JTAG_IDCODE,
  parameter logic [IR_WIDTH-1:0]  IR_IDCODE    = IR_WIDTH'(JTAG_IR_IDCODE),
  parameter logic [IR_WIDTH-1:0]  IR_USER      = IR_WIDTH'(JTAG_IR_USER),
  parameter int unsigned          USER_WIDTH   = 8
)(
  input  logic                  tck,
  input  logic                  trst_n,
  input  logic                  tms,
  input  logic                  tdi,
  output logic                  tdo,
  output logic                  tdo_en,
  input  logic [USER_WIDTH-1:0] user_capture,
  output logic [USER_WIDTH-1:0] user_dr,
  output logic                  user_update,
  output logic [IR_WIDTH-1:0]   ir,
  output logic [3:0]            state
);

  logic [3:0]            w_state;
  logic [IR_WIDTH-1:0]   r_ir;
  logic [IR_WIDTH-1:0]   r_ir_sr;
  logic [31:0]           r_idcode_sr;
  logic [USER_WIDTH-1:0] r_user_sr;
  logic [USER_WIDTH-1:0] w_user_shift;
  logic                  r_bypass;
  logic [USER_WIDTH-1:0] r_user_dr;
  logic                  r_user_update;
  logic                  r_tdo;
  logic                  r_tdo_en;
  logic                  w_sel_idcode;
  logic                  w_sel_user;
  logic                  w_dr_lsb;

  jtag_tap_fsm u_fsm (
    .tck    (tck),
    .trst_n (trst_n),
    .tms    (tms),
    .state  (w_state)
  );

  // IDCODE wins if both opcodes are configured identically; everything else is BYPASS.
  assign w_sel_idcode = (r_ir == IR_IDCODE);
  assign w_sel_user   = (r_ir == IR_USER) && !w_sel_idcode;
  assign w_dr_lsb     = w_sel_idcode ? r_idcode_sr[0] :
                        w_sel_user   ? r_user_sr[0]   : r_bypass;

  generate
    if (USER_WIDTH > 1) begin : g_user_wide
      assign w_user_shift = {tdi, r_user_sr[USER_WIDTH-1:1]};
    end else begin : g_user_bit
      assign w_user_shift = tdi;
    end
  endgenerate

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      r_ir    <= IR_IDCODE;
      r_ir_sr <= '0;
    end else begin
      case (w_state)
        TAP_TEST_LOGIC_RESET: r_ir    <= IR_IDCODE;
        TAP_CAPTURE_IR:       r_ir_sr <= IR_WIDTH'(JTAG_IR_CAPTURE);
        TAP_SHIFT_IR:         r_ir_sr <= {tdi, r_ir_sr[IR_WIDTH-1:1]};
        TAP_UPDATE_IR:        r_ir    <= r_ir_sr;
        default:              ;
      endcase
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      r_idcode_sr <= '0;
      r_user_sr   <= '0;
      r_bypass    <= 1'b0;
    end else if (w_state == TAP_CAPTURE_DR) begin
      if (w_sel_idcode) r_idcode_sr <= IDCODE_VALUE;
      if (w_sel_user)   r_user_sr   <= user_capture;
      if (!w_sel_idcode && !w_sel_user) r_bypass <= 1'b0;
    end else if (w_state == TAP_SHIFT_DR) begin
      if (w_sel_idcode) r_idcode_sr <= {tdi, r_idcode_sr[31:1]};
      if (w_sel_user)   r_user_sr   <= w_user_shift;
      if (!w_sel_idcode && !w_sel_user) r_bypass <= tdi;
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      r_user_dr     <= '0;
      r_user_update <= 1'b0;
    end else begin
      r_user_update <= (w_state == TAP_UPDATE_DR) && w_sel_user;
      if ((w_state == TAP_UPDATE_DR) && w_sel_user) r_user_dr <= r_user_sr;
    end
  end

  // Launch on the falling edge so the far end samples a stable bit on the next rise.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else if (w_state == TAP_SHIFT_IR) begin
      r_tdo    <= r_ir_sr[0];
      r_tdo_en <= 1'b1;
    end else if (w_state == TAP_SHIFT_DR) begin
      r_tdo    <= w_dr_lsb;
      r_tdo_en <= 1'b1;
    end else begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end
  end

  assign tdo         = r_tdo;
  assign tdo_en      = r_tdo_en;
  assign user_dr     = r_user_dr;
  assign user_update = r_user_update;
  assign ir          = r_ir;
  assign state       = w_state;

endmodule

// File: tb/tb_jtag_tap.sv
// Bench for jtag_tap: directed plan scenarios with literal checks, then random TMS/TDI
// traffic compared every tck against a table-driven behavioural model.
module tb_jtag_tap;

  localparam logic [3:0]  IR_IDC = 4'b1110;
  localparam logic [3:0]  IR_USR = 4'b1010;
  localparam logic [31:0] IDCODE = 32'h000FAF01;

  logic       tck = 1'b0;
  logic       trst_n = 1'b0;
  logic       tms = 1'b1;
  logic       tdi = 1'b0;
  logic [7:0] user_capture = 8'h00;
  logic       tdo, tdo_en, user_update;
  logic [7:0] user_dr;
  logic [3:0] ir;
  logic [3:0] state;

  jtag_tap dut (
    .tck          (tck),
    .trst_n       (trst_n),
    .tms          (tms),
    .tdi          (tdi),
    .tdo          (tdo),
    .tdo_en       (tdo_en),
    .user_capture (user_capture),
    .user_dr      (user_dr),
    .user_update  (user_update),
    .ir           (ir),
    .state        (state)
  );

  always #5 tck = ~tck;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: IEEE TAP transition table indexed by [state], one table per tms value.
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int          m_state;
  logic [3:0]  m_ir, m_irsh;
  logic [31:0] m_dr;
  logic [7:0]  m_user_dr;
  logic        m_upd;
  int          m_len;

  function automatic int dr_len(input logic [3:0] op);
    return (op == IR_IDC) ? 32 : (op == IR_USR) ? 8 : 1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_ir = IR_IDC; m_irsh = 4'h0; m_dr = 32'h0;
    m_user_dr = 8'h00; m_upd = 1'b0;
  endtask

  always @(negedge trst_n) model_reset();

  always @(posedge tck) begin
    if (trst_n) begin
      m_len = dr_len(m_ir);
      m_upd = (m_state == 8) && (m_ir == IR_USR);
      if (m_upd) m_user_dr = m_dr[7:0];
      if (m_state == 3)
        m_dr = (m_ir == IR_IDC) ? IDCODE : (m_ir == IR_USR) ? {24'h0, user_capture} : 32'h0;
      if (m_state == 4) m_dr = (m_dr >> 1) | ({31'h0, tdi} << (m_len - 1));
      if (m_state == 10) m_irsh = 4'b0001;
      if (m_state == 11) m_irsh = (m_irsh >> 1) | ({3'h0, tdi} << 3);
      if (m_state == 15) m_ir = m_irsh;
      if (m_state == 0) m_ir = IR_IDC;
      m_state = tms ? nxt1[m_state] : nxt0[m_state];
    end
  end

  // Per-cycle compare, half a cycle away from the state-changing rise.
  always @(negedge tck) begin
    logic exp_en, exp_tdo;
    #1;
    exp_en  = (m_state == 4) || (m_state == 11);
    exp_tdo = !exp_en ? 1'b0 : (m_state == 11) ? m_irsh[0] : m_dr[0];
    cmp("state", 32'(state), 32'(m_state));
    cmp("ir", 32'(ir), 32'(m_ir));
    cmp("user_dr", 32'(user_dr), 32'(m_user_dr));
    cmp("user_update", 32'(user_update), 32'(m_upd));
    cmp("tdo_en", 32'(tdo_en), 32'(exp_en));
    cmp("tdo", 32'(tdo), 32'(exp_tdo));
  end

  // Recorder of shifted-out bits and user_update pulses for the literal checks.
  logic [63:0] rec;
  int          rec_n = 0;
  int          upd_cnt = 0;
  always @(negedge tck) begin
    #1;
    if (tdo_en && rec_n < 64) begin
      rec[rec_n] = tdo;
      rec_n++;
    end
    if (user_update) upd_cnt++;
  end

  task automatic rec_clear();
    rec = 64'h0;
    rec_n = 0;
  endtask

  task automatic step(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge tck);
    #2;
  endtask

  task automatic goto_idle();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic shift_ir(input logic [3:0] v);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(i == 3, v[i]);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic shift_dr(input logic [31:0] v, input int n);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) step(i == n - 1, v[i]);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, n_cmp %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int upd0;
    model_reset();
    repeat (3) @(posedge tck);
    #2;
    cmp("rst_state", 32'(state), 32'd0);
    cmp("rst_ir", 32'(ir), 32'(IR_IDC));
    cmp("rst_tdo_en", 32'(tdo_en), 32'd0);
    cmp("rst_user_dr", 32'(user_dr), 32'd0);
    trst_n = 1'b1;

    // IDCODE straight out of reset
    rec_clear();
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) step(i == 31, 1'b0);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    cmp("idcode_bits", rec[31:0], 32'h000FAF01);
    cmp("idcode_count", 32'(rec_n), 32'd32);

    // IR capture pattern and load of all-ones
    rec_clear();
    shift_ir(4'hF);
    cmp("ir_capture_bits", rec[31:0], 32'h1);
    cmp("ir_capture_count", 32'(rec_n), 32'd4);
    cmp("ir_loaded", 32'(ir), 32'hF);

    // Bypass: one tck of delay
    rec_clear();
    shift_dr(32'hA5, 8);
    cmp("bypass_bits", rec[31:0], 32'h4A);
    cmp("bypass_count", 32'(rec_n), 32'd8);
    cmp("bypass_no_update", 32'(upd_cnt), 32'd0);

    // User DR capture/update
    shift_ir(IR_USR);
    cmp("ir_user", 32'(ir), 32'(IR_USR));
    user_capture = 8'h3C;
    upd0 = upd_cnt;
    rec_clear();
    shift_dr(32'h81, 8);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    cmp("user_capture_bits", rec[31:0], 32'h3C);
    cmp("user_dr_updated", 32'(user_dr), 32'h81);
    cmp("user_update_pulses", 32'(upd_cnt - upd0), 32'd1);

    // TMS reset from PauseDr; shift register holds user_dr so the pass through UpdateDr is benign
    user_capture = 8'h81;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    cmp("pause_dr_state", 32'(state), 32'd6);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    cmp("tms_reset_state", 32'(state), 32'd0);
    step(1'b1, 1'b0);
    cmp("tms_reset_ir", 32'(ir), 32'(IR_IDC));
    cmp("tms_reset_user_dr", 32'(user_dr), 32'h81);
    step(1'b0, 1'b0);

    // Asynchronous reset in the middle of a user DR shift
    shift_ir(IR_USR);
    user_capture = 8'h55;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    cmp("midshift_tdo_en", 32'(tdo_en), 32'd1);
    upd0 = upd_cnt;
    #1 trst_n = 1'b0;
    #1;
    cmp("arst_state", 32'(state), 32'd0);
    cmp("arst_ir", 32'(ir), 32'(IR_IDC));
    cmp("arst_tdo", 32'(tdo), 32'd0);
    cmp("arst_tdo_en", 32'(tdo_en), 32'd0);
    cmp("arst_user_dr", 32'(user_dr), 32'd0);
    cmp("arst_user_update", 32'(user_update), 32'd0);
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    trst_n = 1'b1;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    cmp("arst_no_update", 32'(upd_cnt - upd0), 32'd0);

    // Random traffic against the model
    for (int k = 0; k < 60; k++) begin
      logic [3:0] op;
      int sel;
      goto_idle();
      sel = $urandom_range(0, 2);
      op = (sel == 0) ? IR_IDC : (sel == 1) ? IR_USR : 4'($urandom);
      shift_ir(op);
      for (int i = 0; i < 40; i++) begin
        user_capture = 8'($urandom);
        if ($urandom_range(0, 149) == 0) begin
          #1 trst_n = 1'b0;
          step(1'b1, 1'b0);
          trst_n = 1'b1;
        end
        step($urandom_range(0, 3) == 0, 1'($urandom));
      end
    end

    trst_n = 1'b1;
    step(1'b1, 1'b0);
    @(negedge tck);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtag_tap.md
# jtag_tap

Parametrised IEEE 1149.1-style TAP controller, successor to the single-instruction TAP. Implements the full 16-state TAP FSM with a real IR shift/update path, IDCODE, BYPASS and one user data register of configurable width, all shifted LSB-first. Sits at the chip boundary on the `tck` domain and exposes the user register to the core as a capture/update interface.

## Interface

- `IR_WIDTH`, 4: instruction register width, ≥2.
- `IDCODE_VALUE`, 32'h000FAF01: IDCODE DR contents; bit 0 must be 1.
- `IR_IDCODE`, 4'b1110: IDCODE opcode, reset value of IR.
- `IR_USER`, 4'b1010: opcode selecting the user DR.
- `USER_WIDTH`, 8: user DR width, ≥1.

Ports:

- `tck` input 1: TAP clock, the only clock. Rising edge for all state; falling edge for `tdo`/`tdo_en` only.
- `trst_n` input 1: reset; asynchronous, active-low.
- `tms` input 1: mode select, sampled on `tck` rise.
- `tdi` input 1: serial data in, sampled on `tck` rise.
- `tdo` output 1: serial data out, changes on `tck` fall.
- `tdo_en` output 1: high while `tdo` carries shift data.
- `user_capture` input USER_WIDTH: value loaded into the user shift register in CaptureDr.
- `user_dr` output USER_WIDTH: last updated user register value.
- `user_update` output 1: one-cycle pulse when `user_dr` changes.
- `ir` output IR_WIDTH: current active instruction.
- `state` output 4: current TAP state, for debug/formal.

## Operation

- FSM states and TMS transitions per IEEE 1149.1: TestLogicReset, RunTestIdle, SelectDr, CaptureDr, ShiftDr, Exit1Dr, PauseDr, Exit2Dr, UpdateDr, and the matching Ir states.
- SelectIr with tms=1 goes to TestLogicReset.
- Shift states stay in Shift on tms=0 unconditionally. There is no auto-exit.
- Instruction decode:
  - `ir==IR_IDCODE`: 32-bit IDCODE DR.
  - `ir==IR_USER`: user DR.
  - Any other value, including all-ones: 1-bit BYPASS.
- CaptureIr: IR shift register loads `{IR_WIDTH-2 zeros, 2'b01}`.
- CaptureDr loads the selected DR:
  - IDCODE: `IDCODE_VALUE`.
  - User: `user_capture`.
  - Bypass: 0.
- ShiftIr/ShiftDr: selected shift register shifts right one bit per rising edge; `tdi` enters the MSB.
- UpdateIr, on the rising edge leaving it: `ir` ← IR shift register.
- UpdateDr with user selected, on the rising edge leaving it: `user_dr` ← user shift register. `user_update` is high for exactly the following `tck` cycle.
- TestLogicReset, synchronous, every cycle in the state: `ir` ← `IR_IDCODE`. `user_dr` is unchanged.
- Five consecutive tms=1 rising edges from any state reach TestLogicReset.

## Timing

- Outputs while `trst_n` is low, immediately and asynchronously:
  - `state` = TestLogicReset.
  - `ir` = `IR_IDCODE`.
  - `tdo` = 0, `tdo_en` = 0.
  - `user_dr` = 0, `user_update` = 0.
  - All shift registers = 0.
- Reset may assert mid-shift. Shift contents are discarded and no update occurs.
- Falling edge of `tck`:
  - While `state` is ShiftDr/ShiftIr: `tdo` ← LSB of the selected shift register, `tdo_en` ← 1.
  - Otherwise: `tdo_en` ← 0 and `tdo` holds 0.
- The first `tdo` bit is valid half a cycle after entering Shift. An N-bit register needs N rising edges in Shift, the last with tms=1.
- Bypass adds exactly one `tck` of delay from `tdi` to `tdo`.
- Pause states hold all shift-register contents indefinitely.

## Structure

- Shared package `jtag_pkg`:
  - 4-bit TAP state localparams (TestLogicReset=0 … UpdateIr=15).
  - Default opcode constants.
  - IR capture pattern.
- Sub-module `jtag_tap_fsm`: pure next-state logic plus state register (`tck`, `trst_n`, `tms` → `state`). Reusable and separately formally checked.
- The datapath (shift registers, decode, output stage) lives in `jtag_tap`.

## Test plan

- IDCODE after reset: pulse `trst_n`; tms 0,1,0,0 into ShiftDr; 32 shifts (last with tms=1) → `tdo` bits LSB-first = 0x000FAF01, `tdo_en` high for exactly 32 falls.
- IR capture/load: go to ShiftIr; shift in 4'b1111 → `tdo` shows 1,0,0,0; after UpdateIr `ir`=4'b1111.
- Bypass: with `ir`=4'b1111, shift 8 bits of 0xA5 through DR → `tdo` sequence is 0 followed by the first 7 bits of 0xA5 LSB-first.
- User DR: load `IR_USER`, `user_capture`=0x3C, shift in 0x81 → `tdo` outputs 0x3C LSB-first. After UpdateDr, `user_dr`=0x81 and `user_update` is high for one cycle only.
- TMS reset: from PauseDr with `ir`=IR_USER, apply 5× tms=1 → `state`=TestLogicReset, `ir`=IR_IDCODE, `user_dr` unchanged.
- Async reset mid-shift: drop `trst_n` between clock edges during ShiftDr → all outputs at reset values before the next edge; `user_update` never pulses.
